// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller for a first-word-fall-through FIFO
// built around a 2**ADDR_WIDTH entry register file with combinational read.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH  = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT1   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR1   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok, pop_ok;

  // Accept decisions use registered flags only. A push into a full FIFO is
  // allowed when a pop happens the same cycle: the write reuses the slot
  // whose data was already read combinationally.
  always_comb begin
    push_ok = wr & (~full_q | rd);
    pop_ok  = rd & ~empty_q;
    wr_en   = push_ok & ~reset;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    full_d  = full_q;
    empty_d = empty_q;
    ovf_d   = ovf_q | (wr & ~push_ok);
    unf_d   = unf_q | (rd & empty_q);
    if (push_ok) w_ptr_d = w_ptr_q + PTR1;
    if (pop_ok)  r_ptr_d = r_ptr_q + PTR1;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT1;
      empty_d = 1'b0;
      full_d  = (count_q + CNT1) == DEPTH;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT1;
      full_d  = 1'b0;
      empty_d = (count_q - CNT1) == '0;
    end
  end

  // State registers with synchronous reset that discards all contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign w_addr    = w_ptr_q;
  assign r_addr    = r_ptr_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl at depth 4.
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset, wr, rd;
  logic       wr_en, empty, full, overflow, underflow;
  logic [1:0] w_addr, r_addr;
  logic [2:0] count;
  int errors = 0;
  int checks = 0;

  fifo_ctrl #(.ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .wr_en(wr_en),
    .w_addr(w_addr), .r_addr(r_addr), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later
  // (combinational) or 1 time unit after the rising edge (registered).
  task automatic drive(input logic r, input logic w, input logic d);
    @(negedge clk);
    reset = r; wr = w; rd = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count, empty, full, overflow, underflow, w_addr, r_addr} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d e=%b f=%b ov=%b un=%b wa=%0d ra=%0d, want 0 1 0 0 0 0 0",
               count, empty, full, overflow, underflow, w_addr, r_addr);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if (wr_en !== 1'b1 || w_addr !== 2'(i)) begin
        errors++;
        $display("FAIL fill_wr_en[%0d]: wr_en=%b w_addr=%0d, want 1 %0d", i, wr_en, w_addr, i);
      end
      tick();
      checks++;
      if (count !== 3'(i + 1) || empty !== 1'b0 || full !== (i == 3)) begin
        errors++;
        $display("FAIL fill_count[%0d]: cnt=%0d e=%b f=%b, want %0d 0 %b", i, count, empty, full, i + 1, i == 3);
      end
    end
    checks++;
    if (w_addr !== 2'd0) begin
      errors++;
      $display("FAIL fill_wrap: w_addr=%0d, want 0", w_addr);
    end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wr_en: wr_en=%b, want 0", wr_en);
    end
    tick();
    checks++;
    if (w_addr !== 2'd0 || count !== 3'd4 || overflow !== 1'b1 || full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_state: wa=%0d cnt=%0d ov=%b f=%b, want 0 4 1 1", w_addr, count, overflow, full);
    end
    drive(1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: ov=%b, want 1", overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      checks++;
      if (r_addr !== 2'(i)) begin
        errors++;
        $display("FAIL drain_raddr[%0d]: r_addr=%0d, want %0d", i, r_addr, i);
      end
      tick();
      checks++;
      if (count !== 3'(3 - i) || full !== 1'b0 || empty !== (i == 3)) begin
        errors++;
        $display("FAIL drain_count[%0d]: cnt=%0d f=%b e=%b, want %0d 0 %b", i, count, full, empty, 3 - i, i == 3);
      end
    end
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL drain_no_unf: un=%b, want 0", underflow);
    end
    drive(1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (r_addr !== 2'd0 || count !== 3'd0 || underflow !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL unf_state: ra=%0d cnt=%0d un=%b e=%b, want 0 0 1 1", r_addr, count, underflow, empty);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      checks++;
      if (wr_en !== 1'b1) begin
        errors++;
        $display("FAIL b2b_wr_en[%0d]: wr_en=%b, want 1", i, wr_en);
      end
      tick();
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count[%0d]: cnt=%0d, want 2", i, count);
      end
    end
    checks++;
    if (w_addr !== 2'd0 || r_addr !== 2'd2) begin
      errors++;
      $display("FAIL b2b_ptrs: wa=%0d ra=%0d, want 0 2", w_addr, r_addr);
    end
  endtask

  task automatic test_simul_edges();
    do_reset();
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL empty_wr_en: wr_en=%b, want 1", wr_en);
    end
    tick();
    checks++;
    if (count !== 3'd1 || r_addr !== 2'd0 || w_addr !== 2'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_wr_rd: cnt=%0d ra=%0d wa=%0d un=%b e=%b, want 1 0 1 1 0",
               count, r_addr, w_addr, underflow, empty);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (count !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL refill: cnt=%0d f=%b, want 4 1", count, full);
    end
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL full_wr_en: wr_en=%b, want 1", wr_en);
    end
    tick();
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || w_addr !== 2'd1 || r_addr !== 2'd1) begin
      errors++;
      $display("FAIL full_wr_rd: cnt=%0d f=%b ov=%b wa=%0d ra=%0d, want 4 1 0 1 1",
               count, full, overflow, w_addr, r_addr);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    checks++;
    if (count !== 3'd3 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: cnt=%0d un=%b, want 3 1", count, underflow);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_en: wr_en=%b, want 0", wr_en);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if ({count, empty, full, overflow, underflow, w_addr, r_addr} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset: cnt=%0d e=%b f=%b ov=%b un=%b wa=%0d ra=%0d, want 0 1 0 0 0 0 0",
               count, empty, full, overflow, underflow, w_addr, r_addr);
    end
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    test_simul_edges();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
